// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall controller: stall vectors, multi-cycle
// op kinds and sequencer state codes.
package pipe_stall_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int unsigned StallW = 6;

  // Bit order: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
  localparam logic [StallW-1:0] StallNone = 6'b000000;
  localparam logic [StallW-1:0] StallIf   = 6'b000011;
  localparam logic [StallW-1:0] StallId   = 6'b000111;
  localparam logic [StallW-1:0] StallEx   = 6'b001111;
  localparam logic [StallW-1:0] StallMem  = 6'b011111;

  localparam logic [1:0] McDiv  = 2'b01;
  localparam logic [1:0] McMadd = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } mc_state_e;

  function automatic logic mc_kind_valid(input logic [1:0] kind);
    return (kind == McDiv) || (kind == McMadd);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mc_seq_fsm.sv
// Multi-cycle EX op sequencer: holds EX for N cycles after a start, then raises
// done until the EX stage is no longer stalled.
module pipe_stall_ctrl_mc_seq_fsm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DivCycles  = 33,
  parameter int unsigned MaddCycles = 2,
  parameter int unsigned CntW       = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [1:0] kind_i,
  input  logic       flush_i,
  input  logic       mem_stall_i,
  input  logic       ex_stall_i,
  output logic       hold_o,
  output logic       busy_o,
  output logic       done_o
);

  mc_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             start_ok;
  logic [CntW-1:0]  cnt_load;

  // A start under a memory stall is dropped; EX presents it again later.
  assign start_ok = start_i & mc_kind_valid(kind_i) & ~flush_i & ~mem_stall_i;
  assign cnt_load = (kind_i == McDiv) ? CntW'(DivCycles - 1) : CntW'(MaddCycles - 1);

  assign hold_o = ((state_q == StIdle) & start_ok) | (state_q == StBusy);
  assign busy_o = (state_q == StBusy) & ~flush_i;
  assign done_o = (state_q == StDone) & ~flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StBusy;
          cnt_d   = cnt_load;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (ex_stall_i == NoStop) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: priority-merges stage stall requests into the
// stall vector, sequences multi-cycle EX ops and counts stalled cycles.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES  = 33,
  parameter int unsigned MADD_CYCLES = 2,
  parameter int unsigned CNT_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              ex_mc_start,
  input  logic [1:0]        ex_mc_kind,
  input  logic              flush,
  output logic [StallW-1:0] stall,
  output logic              ex_mc_busy,
  output logic              ex_mc_done,
  output logic [31:0]       stall_cycles
);

  logic        mc_hold;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  pipe_stall_ctrl_mc_seq_fsm #(
    .DivCycles  (DIV_CYCLES),
    .MaddCycles (MADD_CYCLES),
    .CntW       (CNT_W)
  ) u_mc_seq_fsm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .start_i     (ex_mc_start),
    .kind_i      (ex_mc_kind),
    .flush_i     (flush),
    .mem_stall_i (stallreq_mem),
    .ex_stall_i  (stall[3]),
    .hold_o      (mc_hold),
    .busy_o      (ex_mc_busy),
    .done_o      (ex_mc_done)
  );

  // Stall vector is forced quiet while reset is asserted, whatever the requests.
  always_comb begin
    stall = StallNone;
    if (!rst || flush) begin
      stall = StallNone;
    end else if (stallreq_mem) begin
      stall = StallMem;
    end else if (stallreq_ex || mc_hold) begin
      stall = StallEx;
    end else if (stallreq_id) begin
      stall = StallId;
    end else if (stallreq_if) begin
      stall = StallIf;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall[0] == Stop) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
